// File: rtl/add_pipe_reduce.sv
// add_pipe_reduce: pipelined adder with valid/ready handshakes on both sides.
// The add is done at the smallest width that can hold the sum (AW bits).
// That width is split into CHUNK_WIDTH carry segments, one per pipeline
// stage. Each stage hands on only the operand bits still to be added plus
// the sum bits finished so far. Result bits above AW are rebuilt by extension.
module add_pipe_reduce #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int Y_WIDTH     = 32,
    parameter int A_SIGNED    = 0,
    parameter int B_SIGNED    = 0,
    parameter int CHUNK_WIDTH = 8,
    parameter int Y_MIN_WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] y
);

    localparam bit SIGNED  = (A_SIGNED != 0) && (B_SIGNED != 0);
    localparam int MAX_AB  = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
    localparam int FLOOR_W = (Y_MIN_WIDTH > MAX_AB + 1) ? Y_MIN_WIDTH : MAX_AB + 1;
    localparam int AW      = (Y_WIDTH < FLOOR_W) ? Y_WIDTH : FLOOR_W;
    localparam int N       = (AW + CHUNK_WIDTH - 1) / CHUNK_WIDTH;

    logic [AW-1:0] a_ext;
    logic [AW-1:0] b_ext;
    logic [N-1:0]  v;
    logic [N-1:0]  rdy;
    logic          rdy_acc;

    if (A_WIDTH >= AW) begin : g_a_trunc
        assign a_ext = a[AW-1:0];
    end else begin : g_a_ext
        assign a_ext = {{(AW-A_WIDTH){SIGNED & a[A_WIDTH-1]}}, a};
    end

    if (B_WIDTH >= AW) begin : g_b_trunc
        assign b_ext = b[AW-1:0];
    end else begin : g_b_ext
        assign b_ext = {{(AW-B_WIDTH){SIGNED & b[B_WIDTH-1]}}, b};
    end

    // Stage k may load when it is empty or when some stage downstream of it
    // (or the consumer) can take data. Built as a running OR from the output end.
    always_comb begin
        rdy_acc = out_ready;
        rdy     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rdy_acc = rdy_acc | ~v[i];
            rdy[i]  = rdy_acc;
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < N; k++) begin : stg
        localparam int LO = k * CHUNK_WIDTH;
        localparam int HI = (LO + CHUNK_WIDTH > AW) ? AW - 1 : LO + CHUNK_WIDTH - 1;
        localparam int W  = HI - LO + 1;

        logic [AW-LO-1:0] src_a;
        logic [AW-LO-1:0] src_b;
        logic             src_c;
        logic             src_v;
        logic [W-1:0]     sum_lo;
        logic [HI:0]      s_next;
        logic             v_r;
        logic [HI:0]      s_r;

        if (k == 0) begin : g_first
            assign src_a  = a_ext;
            assign src_b  = b_ext;
            assign src_c  = 1'b0;
            assign src_v  = in_valid;
            assign s_next = sum_lo;
        end else begin : g_next
            assign src_a  = stg[k-1].g_fwd.a_r;
            assign src_b  = stg[k-1].g_fwd.b_r;
            assign src_c  = stg[k-1].g_fwd.c_r;
            assign src_v  = stg[k-1].v_r;
            assign s_next = {sum_lo, stg[k-1].s_r};
        end

        if (k < N - 1) begin : g_fwd
            localparam int RW = AW - HI - 1;
            logic [W:0]    sum_w;
            logic [RW-1:0] a_r;
            logic [RW-1:0] b_r;
            logic          c_r;

            assign sum_w  = {1'b0, src_a[W-1:0]} + {1'b0, src_b[W-1:0]} + (W+1)'(src_c);
            assign sum_lo = sum_w[W-1:0];

            // Skew registers: operand bits not yet added, plus carry into the next chunk.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                end else if (rdy[k]) begin
                    a_r <= src_a[AW-LO-1:W];
                    b_r <= src_b[AW-LO-1:W];
                    c_r <= sum_w[W];
                end
            end
        end else begin : g_last
            // The carry out of the top chunk is dropped, so the sum wraps modulo 2^AW.
            assign sum_lo = src_a[W-1:0] + src_b[W-1:0] + W'(src_c);
        end

        // Stage valid and the sum bits finished so far; both hold while stalled.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
                s_r <= '0;
            end else if (rdy[k]) begin
                v_r <= src_v;
                s_r <= s_next;
            end
        end

        assign v[k] = v_r;
    end

    assign out_valid   = v[N-1];
    assign y[AW-1:0]   = stg[N-1].s_r;

    if (Y_WIDTH > AW) begin : g_y_ext
        assign y[Y_WIDTH-1:AW] = {(Y_WIDTH-AW){SIGNED & stg[N-1].s_r[AW-1]}};
    end

endmodule

// File: tb/tb_add_pipe_reduce.sv
// Directed bench for add_pipe_reduce: five parameterisations share one input
// stream. Each result is checked against a hand-computed value and latency.
module tb_add_pipe_reduce;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        ir_def, ov_def, ir_ss, ov_ss, ir_as, ov_as, ir_tr, ov_tr, ir_c4, ov_c4;
    logic [31:0] y_def, y_ss, y_as, y_c4;
    logic [11:0] y_tr;

    logic        ov_all [5];
    logic        ir_all [5];
    logic [31:0] y_all  [5];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add_pipe_reduce u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_def), .a(a), .b(b),
        .out_valid(ov_def), .out_ready(out_ready), .y(y_def));

    add_pipe_reduce #(.A_SIGNED(1), .B_SIGNED(1)) u_ss (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_ss), .a(a), .b(b),
        .out_valid(ov_ss), .out_ready(out_ready), .y(y_ss));

    add_pipe_reduce #(.A_SIGNED(1)) u_as (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_as), .a(a), .b(b),
        .out_valid(ov_as), .out_ready(out_ready), .y(y_as));

    add_pipe_reduce #(.Y_WIDTH(12)) u_tr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_tr), .a(a), .b(b),
        .out_valid(ov_tr), .out_ready(out_ready), .y(y_tr));

    add_pipe_reduce #(.CHUNK_WIDTH(4)) u_c4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_c4), .a(a), .b(b),
        .out_valid(ov_c4), .out_ready(out_ready), .y(y_c4));

    assign ov_all[0] = ov_def;  assign ir_all[0] = ir_def;  assign y_all[0] = y_def;
    assign ov_all[1] = ov_ss;   assign ir_all[1] = ir_ss;   assign y_all[1] = y_ss;
    assign ov_all[2] = ov_as;   assign ir_all[2] = ir_as;   assign y_all[2] = y_as;
    assign ov_all[3] = ov_tr;   assign ir_all[3] = ir_tr;   assign y_all[3] = {20'h0, y_tr};
    assign ov_all[4] = ov_c4;   assign ir_all[4] = ir_c4;   assign y_all[4] = y_c4;

    string dn [5] = '{"def", "ss", "as", "tr", "c4"};
    int    elat [5] = '{3, 3, 3, 2, 5};

    logic [15:0] va [6] = '{16'hFFFF, 16'h8000, 16'h0FFF, 16'h1234, 16'h7FFF, 16'hFFFF};
    logic [15:0] vb [6] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
    // columns: def, ss, as, tr, c4
    logic [31:0] ey [6][5] = '{
        '{32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000},
        '{32'h0001_7FFF, 32'hFFFF_7FFF, 32'h0001_7FFF, 32'h0000_0FFF, 32'h0001_7FFF},
        '{32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000},
        '{32'h0000_1235, 32'h0000_1235, 32'h0000_1235, 32'h0000_0235, 32'h0000_1235},
        '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h0000_8000},
        '{32'h0001_FFFE, 32'hFFFF_FFFE, 32'h0001_FFFE, 32'h0000_0FFE, 32'h0001_FFFE}
    };

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One vector into an empty pipeline with out_ready=1; latency counted in
    // negedges after the accepting posedge.
    task automatic apply_vec(input int i);
        int          lat [5];
        logic [31:0] yv  [5];
        for (int d = 0; d < 5; d++) begin
            lat[d] = -1;
            yv[d]  = '0;
        end
        out_ready = 1'b1;
        a         = va[i];
        b         = vb[i];
        in_valid  = 1'b1;
        #1;
        for (int d = 0; d < 5; d++)
            check_eq($sformatf("v%0d_%s_in_ready", i, dn[d]), ir_all[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            for (int d = 0; d < 5; d++) begin
                if (ov_all[d] && lat[d] < 0) begin
                    lat[d] = c;
                    yv[d]  = y_all[d];
                end
            end
            @(negedge clk);
        end
        for (int d = 0; d < 5; d++) begin
            check_eq($sformatf("v%0d_%s_latency", i, dn[d]), lat[d], elat[d]);
            check_eq($sformatf("v%0d_%s_y", i, dn[d]), yv[d], ey[i][d]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, rcv, cyc, lat;
        bit  [2:0]   mv;
        bit          stall, exp_ir, r0, r1, r2;
        logic [31:0] held, yv;
        bit          pat [4];

        pat       = '{1'b1, 1'b0, 1'b0, 1'b1};
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 5; d++) begin
            check_eq($sformatf("rst_%s_out_valid", dn[d]), ov_all[d], 1'b0);
            check_eq($sformatf("rst_%s_y", dn[d]), y_all[d], 32'h0);
            check_eq($sformatf("rst_%s_in_ready", dn[d]), ir_all[d], 1'b1);
        end
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_vec(i);

        // Stream of 8 pairs into the default instance with out_ready 1,0,0,1.
        idx   = 0;
        rcv   = 0;
        cyc   = 0;
        mv    = '0;
        stall = 1'b0;
        held  = '0;
        while (rcv < 8 && cyc < 100) begin
            out_ready = pat[cyc % 4];
            in_valid  = (idx < 8);
            a         = 16'(idx);
            b         = 16'(idx * 256);
            #1;
            exp_ir = !(mv[0] && mv[1] && mv[2]) || out_ready;
            check_eq("s_in_ready", ir_def, exp_ir);
            check_eq("s_out_valid", ov_def, mv[2]);
            if (stall) check_eq("s_hold_y", y_def, held);
            if (ov_def && out_ready) begin
                check_eq($sformatf("s_y%0d", rcv), y_def, 32'h101 * rcv);
                rcv++;
            end
            stall = ov_def && !out_ready;
            held  = y_def;
            r2 = !mv[2] || out_ready;
            r1 = !mv[1] || r2;
            r0 = !mv[0] || r1;
            if (r2) mv[2] = mv[1];
            if (r1) mv[1] = mv[0];
            if (r0) mv[0] = in_valid;
            if (in_valid && exp_ir) idx++;
            @(negedge clk);
            cyc++;
        end
        check_eq("s_count", rcv, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("s_no_dup", ov_def, 1'b0);
            @(negedge clk);
        end

        // Reset with two results in flight and the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0001;
        b         = 16'h0002;
        @(negedge clk);
        a = 16'h0005;
        b = 16'h0006;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mr_out_valid", ov_def, 1'b0);
        check_eq("mr_y", y_def, 32'h0);
        check_eq("mr_in_ready", ir_def, 1'b1);
        check_eq("mr_c4_out_valid", ov_c4, 1'b0);
        out_ready = 1'b1;
        a         = 16'h0003;
        b         = 16'h0004;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        yv  = '0;
        for (int c = 1; c <= 8; c++) begin
            if (ov_def && lat < 0) begin
                lat = c;
                yv  = y_def;
            end
            @(negedge clk);
        end
        check_eq("mr_latency", lat, 3);
        check_eq("mr_y_sum", yv, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
